// File: rtl/seg7_to_onehot_decoder_if.sv
// ============================================================================
// Module      : seg7_to_onehot_decoder_if
// Description : Sample-side and result-side signal bundle for the 7-segment
//               readback decoder (slave = decoder, master = driver/consumer).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seg7_to_onehot_decoder_if;
    logic       sample_en;
    logic [6:0] seg_in;
    logic       none_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] onehot_out;
    logic [2:0] index_out;
    logic       none_out;
    logic       err_out;
    logic       overrun;
    logic [7:0] err_count;

    modport slave (
        input  sample_en, seg_in, none_in, out_ready,
        output out_valid, onehot_out, index_out, none_out, err_out,
               overrun, err_count
    );

    modport master (
        output sample_en, seg_in, none_in, out_ready,
        input  out_valid, onehot_out, index_out, none_out, err_out,
               overrun, err_count
    );
endinterface

`default_nettype wire

// File: rtl/seg7_to_onehot_decoder.sv
// ============================================================================
// Module      : seg7_to_onehot_decoder
// Description : Stability-filtered 7-segment to index/one-hot decoder with a
//               valid/ready result port. Optional illegal-pattern counter is
//               built when SEG7_ERR_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_to_onehot_decoder #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    seg7_to_onehot_decoder_if.slave     bus
);

    localparam logic [CNT_W-1:0] c_stable_max = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [7:0]       c_last_rst   = 8'h80;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Returns {legal, index}.
    function automatic logic [3:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   f_decode = 4'b1_000;
            7'h06:   f_decode = 4'b1_001;
            7'h5B:   f_decode = 4'b1_010;
            7'h4F:   f_decode = 4'b1_011;
            7'h66:   f_decode = 4'b1_100;
            7'h6D:   f_decode = 4'b1_101;
            7'h7D:   f_decode = 4'b1_110;
            7'h07:   f_decode = 4'b1_111;
            default: f_decode = 4'b0_000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       onehot_q, onehot_d;
    logic [2:0]       index_q, index_d;
    logic             none_q, none_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;

    logic [7:0]       w_sample;
    logic             w_reach;
    logic             w_accept;
    logic [3:0]       w_dec;
    logic             w_is_none;
    logic             w_is_err;
    logic             w_load;

    // A "none" sample collapses to {1,0x00} so seg_in noise cannot split it.
    assign w_sample = {bus.none_in, bus.none_in ? 7'h00 : bus.seg_in};

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        w_reach = 1'b0;
        if (bus.sample_en) begin
            if (w_sample == cand_q) begin
                if (cnt_q != c_stable_max) begin
                    cnt_d   = cnt_q + c_cnt_one;
                    w_reach = (cnt_d == c_stable_max);
                end
            end else begin
                cand_d  = w_sample;
                cnt_d   = c_cnt_one;
                w_reach = (c_cnt_one == c_stable_max);
            end
        end
    end

    assign w_accept  = w_reach && (cand_d != last_q);
    assign w_dec     = f_decode(cand_d[6:0]);
    assign w_is_none = cand_d[7];
    assign w_is_err  = !w_is_none && !w_dec[3];

    always_comb begin
        state_d   = state_q;
        w_load    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_load  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_accept) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d   = last_q;
        onehot_d = onehot_q;
        index_d  = index_q;
        none_d   = none_q;
        err_d    = err_q;
        if (w_load) begin
            last_d = cand_d;
            none_d = w_is_none;
            err_d  = w_is_err;
            if (w_is_none || w_is_err) begin
                onehot_d = 8'h00;
                index_d  = 3'd0;
            end else begin
                onehot_d = 8'h01 << w_dec[2:0];
                index_d  = w_dec[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cand_q    <= 8'h00;
            cnt_q     <= '0;
            last_q    <= c_last_rst;
            onehot_q  <= 8'h00;
            index_q   <= 3'd0;
            none_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            onehot_q  <= onehot_d;
            index_q   <= index_d;
            none_q    <= none_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Counts every illegal accept, including ones lost to overrun.
    always_comb begin
        errcnt_d = errcnt_q;
        if (w_accept && w_is_err && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt_q <= 8'h00;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.err_count = errcnt_q;
`else
    assign bus.err_count = 8'h00;
`endif

    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.onehot_out = onehot_q;
    assign bus.index_out  = index_q;
    assign bus.none_out   = none_q;
    assign bus.err_out    = err_q;
    assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_to_onehot_decoder.sv
// ============================================================================
// Module      : tb_seg7_to_onehot_decoder
// Description : Directed self-checking bench for seg7_to_onehot_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_to_onehot_decoder;

`ifdef SEG7_ERR_COUNT_EN
    localparam bit c_err_en = 1'b1;
`else
    localparam bit c_err_en = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   hs_cnt;
    int   vld_cnt;
    int   base;

    seg7_to_onehot_decoder_if bus ();

    seg7_to_onehot_decoder #(
        .STABLE_CNT (4),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        hs_cnt = 0;
        forever begin
            @(posedge clk);
            if (!rst && bus.out_valid && bus.out_ready) hs_cnt++;
        end
    end

    initial begin
        vld_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) vld_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [6:0] seg, input logic nn,
                         input int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_en = en;
            bus.seg_in    = seg;
            bus.none_in   = nn;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.seg_in    = 7'h00;
        bus.none_in   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   {7'd0, bus.out_valid}, 8'h00);
        chk("rst_onehot",  bus.onehot_out,        8'h00);
        chk("rst_index",   {5'd0, bus.index_out}, 8'h00);
        chk("rst_none",    {7'd0, bus.none_out},  8'h00);
        chk("rst_err",     {7'd0, bus.err_out},   8'h00);
        chk("rst_overrun", {7'd0, bus.overrun},   8'h00);
        chk("rst_errcnt",  bus.err_count,         8'h00);
        rst = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 2);

        // 1: stable digit 4
        drive(1'b1, 7'h66, 1'b0, 3);
        chk("t1_valid_3samp", {7'd0, bus.out_valid}, 8'h00);
        drive(1'b1, 7'h66, 1'b0, 1);
        chk("t1_valid",  {7'd0, bus.out_valid}, 8'h01);
        chk("t1_index",  {5'd0, bus.index_out}, 8'h04);
        chk("t1_onehot", bus.onehot_out,        8'h10);
        chk("t1_err",    {7'd0, bus.err_out},   8'h00);

        // 2: no repeat emission, then none
        base = hs_cnt;
        bus.out_ready = 1'b1;
        drive(1'b1, 7'h66, 1'b0, 20);
        chk("t2_one_hs", 8'(hs_cnt - base),     8'h01);
        chk("t2_idle",   {7'd0, bus.out_valid}, 8'h00);
        bus.out_ready = 1'b0;
        drive(1'b1, 7'h55, 1'b1, 4);
        chk("t2_none_valid",  {7'd0, bus.out_valid}, 8'h01);
        chk("t2_none_out",    {7'd0, bus.none_out},  8'h01);
        chk("t2_none_onehot", bus.onehot_out,        8'h00);
        chk("t2_none_index",  {5'd0, bus.index_out}, 8'h00);
        bus.out_ready = 1'b1;
        drive(1'b0, 7'h00, 1'b0, 1);
        chk("t2_cleared", {7'd0, bus.out_valid}, 8'h00);

        // 3: alternating never settles; sample_en=0 pauses the filter
        base = vld_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'h3F, 1'b0, 1);
            drive(1'b1, 7'h06, 1'b0, 1);
        end
        chk("t3_no_valid", 8'(vld_cnt - base), 8'h00);
        drive(1'b1, 7'h3F, 1'b0, 3);
        drive(1'b0, 7'h06, 1'b0, 5);
        chk("t3_paused", {7'd0, bus.out_valid}, 8'h00);
        bus.out_ready = 1'b0;
        drive(1'b1, 7'h3F, 1'b0, 1);
        chk("t3_valid",  {7'd0, bus.out_valid}, 8'h01);
        chk("t3_index",  {5'd0, bus.index_out}, 8'h00);
        chk("t3_onehot", bus.onehot_out,        8'h01);
        bus.out_ready = 1'b1;
        drive(1'b0, 7'h00, 1'b0, 1);

        // 4: illegal pattern and error counter saturation
        bus.out_ready = 1'b0;
        drive(1'b1, 7'h7F, 1'b0, 4);
        chk("t4_valid",  {7'd0, bus.out_valid}, 8'h01);
        chk("t4_err",    {7'd0, bus.err_out},   8'h01);
        chk("t4_onehot", bus.onehot_out,        8'h00);
        chk("t4_index",  {5'd0, bus.index_out}, 8'h00);
        chk("t4_none",   {7'd0, bus.none_out},  8'h00);
        chk("t4_errcnt1", bus.err_count, c_err_en ? 8'h01 : 8'h00);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 299; i++) begin
            drive(1'b1, 7'h00, 1'b1, 4);
            drive(1'b1, 7'h7F, 1'b0, 4);
        end
        chk("t4_errcnt_sat", bus.err_count, c_err_en ? 8'hFF : 8'h00);
        drive(1'b0, 7'h00, 1'b0, 2);
        chk("t4_cleared", {7'd0, bus.out_valid}, 8'h00);

        // 5: overrun while held
        bus.out_ready = 1'b0;
        drive(1'b1, 7'h5B, 1'b0, 4);
        chk("t5_valid",   {7'd0, bus.out_valid}, 8'h01);
        chk("t5_index",   {5'd0, bus.index_out}, 8'h02);
        chk("t5_ovr0",    {7'd0, bus.overrun},   8'h00);
        drive(1'b1, 7'h4F, 1'b0, 4);
        chk("t5_ovr1",    {7'd0, bus.overrun},   8'h01);
        chk("t5_index_h", {5'd0, bus.index_out}, 8'h02);
        chk("t5_onehot",  bus.onehot_out,        8'h04);
        chk("t5_errcnt",  bus.err_count, c_err_en ? 8'hFF : 8'h00);
        bus.out_ready = 1'b1;
        drive(1'b0, 7'h00, 1'b0, 1);
        chk("t5_drop",    {7'd0, bus.out_valid}, 8'h00);
        chk("t5_sticky",  {7'd0, bus.overrun},   8'h01);

        // 6: asynchronous reset mid-HOLD
        bus.out_ready = 1'b0;
        drive(1'b1, 7'h6D, 1'b0, 4);
        chk("t6_pre_valid", {7'd0, bus.out_valid}, 8'h01);
        chk("t6_pre_index", {5'd0, bus.index_out}, 8'h05);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid",   {7'd0, bus.out_valid}, 8'h00);
        chk("t6_rst_overrun", {7'd0, bus.overrun},   8'h00);
        chk("t6_rst_onehot",  bus.onehot_out,        8'h00);
        chk("t6_rst_index",   {5'd0, bus.index_out}, 8'h00);
        chk("t6_rst_errcnt",  bus.err_count,         8'h00);
        bus.sample_en = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 7'h07, 1'b0, 4);
        chk("t6_valid",  {7'd0, bus.out_valid}, 8'h01);
        chk("t6_index",  {5'd0, bus.index_out}, 8'h07);
        chk("t6_onehot", bus.onehot_out,        8'h80);
        chk("t6_ovr",    {7'd0, bus.overrun},   8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
